// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain -- read-side controller for the team's synchronous fifo.
//
// Watches the fifo `empty` flag, issues `rd_en`, absorbs the fifo's one-cycle
// read latency and presents words downstream on a valid/ready stream through a
// 2-entry skid buffer. Consumers never deal with rd_en timing.
//
// Optional feature macro: FIFO_DRAIN_CNT_EN
//   defined   -> word_count port exists and counts delivered words (wraps).
//   undefined -> no word_count port, no counter; behaviour otherwise identical.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   enable         in   1 = drain the fifo, 0 = stop reading and flush
//   fifo_empty     in   fifo empty flag (registered in the fifo)
//   fifo_data_out  in   fifo read data, valid the cycle after rd_en
//   fifo_rd_en     out  read strobe to the fifo (combinational)
//   m_data         out  downstream data, oldest buffered word
//   m_valid        out  downstream valid
//   m_ready        in   downstream ready
//   busy           out  high whenever the controller is not IDLE
//   word_count     out  delivered-word counter (FIFO_DRAIN_CNT_EN only)
// -----------------------------------------------------------------------------
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_count
`endif
);

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("fifo_drain: DATA_WIDTH and CNT_WIDTH must be at least 1");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            occ_q, occ_d;     // skid buffer occupancy, 0..2
    logic                  infl_q;           // a read was issued last cycle
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head (oldest) entry
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;   // second entry

    logic                  pop;
    logic                  push;
    logic [2:0]            occ_after;        // occupancy once this edge settles

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign busy    = (state_q != ST_IDLE);

    assign pop  = m_valid && m_ready;
    assign push = infl_q;

    // pop implies occ_q != 0, so the subtraction never underflows.
    assign occ_after = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

    // A new read is allowed only if the word it returns will still fit: the
    // buffer after this edge plus the new in-flight word must be <= 2.
    assign fifo_rd_en = enable && (state_q == ST_RUN) && !fifo_empty &&
                        (occ_after <= 3'd1);

    assign occ_d = occ_after[1:0];

    // Skid buffer: buf0 is always the oldest word; pushes land behind it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = fifo_data_out;
                else               buf1_d = fifo_data_out;
            end
            2'b01: begin
                buf0_d = buf1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            default: ;
        endcase
    end

    // Controller. In FLUSH no reads are issued, so the in-flight flag after
    // this edge is 0 and an empty post-edge buffer means fully drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (enable)                 state_d = ST_RUN;
                else if (occ_after == 3'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            infl_q  <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the two buffer entries are reset explicitly because m_data is
        // driven straight from the head entry and must read 0 out of reset.
        if (reset) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Counts handshakes only; enable and FLUSH leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 1'b1;
    end

    assign word_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain -- self-checking bench for fifo_drain.
//
// A queue-based fifo model feeds the DUT. Every word the fifo hands out on a
// read is pushed into an expected queue; a negedge monitor pops and compares
// whenever a downstream handshake occurs. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_drain;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic          enable        = 1'b0;
    logic          m_ready       = 1'b0;
    logic          fifo_empty    = 1'b1;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          busy;
    logic [DW-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
    logic [CW-1:0] word_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_mem[$];   // contents of the attached fifo
    logic [DW-1:0] exp_q[$];      // words read from the fifo, not yet delivered
    int            rd_pulses  = 0;
    int            pops_total = 0;
    logic [DW-1:0] last_pop   = '0;
    logic          hold_prev  = 1'b0;
    logic [DW-1:0] held       = '0;

    fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .word_count    (word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered fifo: data_out and empty update on the edge that consumes a read.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses++;
            if (fifo_mem.size() != 0) begin
                fifo_data_out <= fifo_mem[0];
                exp_q.push_back(fifo_mem[0]);
                void'(fifo_mem.pop_front());
            end
        end
        fifo_empty <= (fifo_mem.size() == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pops_total = 0;
            hold_prev  = 1'b0;
        end else begin
`ifdef FIFO_DRAIN_CNT_EN
            check("word_count", 32'(word_count), 32'(pops_total[CW-1:0]));
`endif
            check("outstanding_le_2", 32'(exp_q.size() <= 2), 32'd1);
            if (fifo_rd_en) check("no_underflow_read", 32'(fifo_empty), 32'd0);
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("word_expected_on_pop", 32'd0, 32'd1);
                else                   check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
                last_pop = m_data;
                pops_total++;
            end
            hold_prev = m_valid && !m_ready;
            held      = m_data;
        end
    end

    task automatic load_seq(input int n, input logic [DW-1:0] first);
        logic [DW-1:0] w;
        w = first;
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(w);
            w = w + 8'd1;
        end
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_rd, base_pop, n, vcnt;
        int first_rd, first_v, last_v;
        logic done;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- 16 words, m_ready high ----------------
        load_seq(16, 8'h01);
        m_ready  = 1'b1;
        base_rd  = rd_pulses;
        base_pop = pops_total;
        enable   = 1'b1;
        first_rd = -1; first_v = -1; last_v = -1; vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                vcnt++;
            end
        end
        check("stream_latency", 32'(first_v - first_rd), 32'd2);
        check("stream_valid_cycles", 32'(vcnt), 32'd16);
        check("stream_consecutive", 32'(last_v - first_v), 32'd15);
        check("stream_rd_pulses", 32'(rd_pulses - base_rd), 32'd16);
        check("stream_delivered", 32'(pops_total - base_pop), 32'd16);
        check("empty_fifo_stays_run", 32'(busy), 32'd1);
        check("empty_fifo_no_valid", 32'(m_valid), 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        check("stream_word_count", 32'(word_count), 32'd16);
`endif
        enable = 1'b0;
        wait_idle("stream_idle");

        // ---------------- 16 words, m_ready toggling ----------------
        load_seq(16, 8'h01);
        base_rd  = rd_pulses;
        base_pop = pops_total;
        enable   = 1'b1;
        n = 0;
        while ((pops_total - base_pop) < 16 && n < 300) begin
            m_ready = (n % 2 == 0);
            tick();
            n++;
        end
        check("toggle_delivered", 32'(pops_total - base_pop), 32'd16);
        check("toggle_rd_pulses", 32'(rd_pulses - base_rd), 32'd16);
        check("toggle_fifo_drained", 32'(fifo_mem.size()), 32'd0);
        m_ready = 1'b1;
        enable  = 1'b0;
        wait_idle("toggle_idle");

        // ---------------- m_ready low, 5 words ----------------
        m_ready = 1'b0;
        load_seq(5, 8'h01);
        base_rd  = rd_pulses;
        base_pop = pops_total;
        enable   = 1'b1;
        repeat (20) tick();
        check("stall_rd_pulses", 32'(rd_pulses - base_rd), 32'd2);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_data", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        n = 0;
        while ((pops_total - base_pop) < 5 && n < 50) begin
            tick();
            n++;
        end
        check("stall_delivered", 32'(pops_total - base_pop), 32'd5);
        check("stall_rd_total", 32'(rd_pulses - base_rd), 32'd5);
        enable = 1'b0;
        wait_idle("stall_idle");

        // ---------------- enable dropped mid-stream -> FLUSH ----------------
        load_seq(16, 8'h01);
        base_rd  = rd_pulses;
        base_pop = pops_total;
        enable   = 1'b1;
        n = 0;
        while ((pops_total - base_pop) < 3 && n < 50) begin
            tick();
            n++;
        end
        check("flush_outstanding", 32'(exp_q.size()), 32'd2);
        enable = 1'b0;
        tick();
        check("flush_busy", 32'(busy), 32'd1);
        wait_idle("flush_idle");
        check("flush_delivered", 32'(pops_total - base_pop), 32'd5);
        check("flush_rd_pulses", 32'(rd_pulses - base_rd), 32'd5);
        check("flush_words_left", 32'(fifo_mem.size()), 32'd11);
        repeat (10) tick();
        check("flush_no_more_reads", 32'(rd_pulses - base_rd), 32'd5);

        // ---------------- reset mid-stream with buffer full ----------------
        m_ready = 1'b0;
        enable  = 1'b1;
        repeat (10) tick();
        check("pre_reset_valid", 32'(m_valid), 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("midreset_m_valid", 32'(m_valid), 32'd0);
        check("midreset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        check("midreset_word_count", 32'(word_count), 32'd0);
`endif
        tick();
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        base_rd = rd_pulses;
        vcnt    = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_valid) vcnt++;
        end
        check("post_reset_silent_valid", 32'(vcnt), 32'd0);
        check("post_reset_silent_rd", 32'(rd_pulses - base_rd), 32'd0);
        base_pop = pops_total;
        enable   = 1'b1;
        n = 0;
        while ((pops_total - base_pop) < 9 && n < 100) begin
            tick();
            n++;
        end
        check("post_reset_delivered", 32'(pops_total - base_pop), 32'd9);
        check("post_reset_last_word", 32'(last_pop), 32'h10);
        enable = 1'b0;
        wait_idle("post_reset_idle");

        // ---------------- single word AA ----------------
        load_seq(1, 8'hAA);
        base_rd  = rd_pulses;
        base_pop = pops_total;
        enable   = 1'b1;
        repeat (10) tick();
        check("single_rd_pulses", 32'(rd_pulses - base_rd), 32'd1);
        check("single_delivered", 32'(pops_total - base_pop), 32'd1);
        check("single_data", 32'(last_pop), 32'hAA);
        check("single_m_valid_after", 32'(m_valid), 32'd0);
        check("single_fifo_empty", 32'(fifo_empty), 32'd1);
        check("single_stays_run", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_idle("single_idle");

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) fifo_mem.push_back(8'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            tick();
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        done    = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            tick();
            done = (fifo_mem.size() == 0) && (exp_q.size() == 0) && !m_valid;
            n++;
        end
        check("random_drain_complete", 32'(done), 32'd1);
        enable = 1'b0;
        wait_idle("random_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
